switch_rd_sched: RTL and testbench

Round-robin read scheduler that drains packets from the switch's per-port input FIFOs onto one shared output channel. It sits between NUM_PORTS FIFO instances and the output stage. It grants one non-empty FIFO at a time and issues single read pulses to that FIFO. Each returned word is forwarded with a valid/ready handshake until the whole packet, header plus LEN payload words, has been transferred.

---
 rtl/switch_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/switch_rd_sched.sv | 161 ++++++++++++++++
 tb/tb_switch_rd_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and default sizing for the switch input-FIFO schedulers.
package switch_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int W_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, with wrap.
module rr_arbiter
    import switch_pkg::*;
#(
    parameter int N     = NUM_PORTS_DEF,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    // cand_idx[k] is the port visited at scan position k (k=0 is last_grant+1)
    logic [IDX_W-1:0] cand_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
            // sum < 2N, so a single conditional subtract performs the wrap
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                         : sum[IDX_W-1:0];
        end
    endgenerate

    // Scan from the far end so the closest requester to last_grant+1 wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant_idx = cand_idx[k];
                any_req   = 1'b1;
            end
        end
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/switch_rd_sched.sv
// Round-robin packet drain from per-port input FIFOs onto one output channel.
// One word in flight at a time: READ pulse, RD_LATENCY wait, OUT handshake.
module switch_rd_sched
    import switch_pkg::*;
#(
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int W_WIDTH    = W_WIDTH_DEF,
    parameter int RD_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           fifo_empty,
    output logic [NUM_PORTS-1:0]           fifo_rd_en,
    input  logic [NUM_PORTS*W_WIDTH-1:0]   fifo_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [W_WIDTH-1:0]             out_data,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [$clog2(NUM_PORTS)-1:0]   out_port,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    sched_state_t         state_reg, state_next;
    logic [PW-1:0]        grant_reg, grant_next;
    logic [NUM_PORTS-1:0] grant_oh_reg, grant_oh_next;
    logic [PW-1:0]        last_grant_reg, last_grant_next;
    logic [W_WIDTH-1:0]   remaining_reg, remaining_next;
    logic                 hdr_flag_reg, hdr_flag_next;
    logic [LW-1:0]        lat_cnt_reg, lat_cnt_next;
    logic [W_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                 out_sop_reg, out_sop_next;
    logic                 out_eop_reg, out_eop_next;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;

    logic [W_WIDTH-1:0]   port_data [NUM_PORTS];
    logic [W_WIDTH-1:0]   rd_word;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_split
            assign port_data[gi] = fifo_rd_data[gi*W_WIDTH +: W_WIDTH];
        end
    endgenerate

    assign rd_word = port_data[grant_reg];

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (PW)
    ) u_arb (
        .req        (~fifo_empty),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_oh_reg   <= '0;
            last_grant_reg <= PW'(NUM_PORTS - 1);
            remaining_reg  <= '0;
            hdr_flag_reg   <= 1'b0;
            lat_cnt_reg    <= '0;
            out_data_reg   <= '0;
            out_sop_reg    <= 1'b0;
            out_eop_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            grant_oh_reg   <= grant_oh_next;
            last_grant_reg <= last_grant_next;
            remaining_reg  <= remaining_next;
            hdr_flag_reg   <= hdr_flag_next;
            lat_cnt_reg    <= lat_cnt_next;
            out_data_reg   <= out_data_next;
            out_sop_reg    <= out_sop_next;
            out_eop_reg    <= out_eop_next;
        end
    end

    // Next-state logic, grant capture and word capture at the end of WAIT
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        grant_oh_next   = grant_oh_reg;
        last_grant_next = last_grant_reg;
        remaining_next  = remaining_reg;
        hdr_flag_next   = hdr_flag_reg;
        lat_cnt_next    = lat_cnt_reg;
        out_data_next   = out_data_reg;
        out_sop_next    = out_sop_reg;
        out_eop_next    = out_eop_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    grant_next     = arb_idx;
                    grant_oh_next  = arb_grant;
                    remaining_next = '0;
                    hdr_flag_next  = 1'b1;
                    state_next     = READ;
                end
            end
            READ: begin
                // An empty granted FIFO is an underrun: wait here, no pulse
                if (!fifo_empty[grant_reg]) begin
                    lat_cnt_next = '0;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_reg == LW'(RD_LATENCY - 1)) begin
                    out_data_next = rd_word;
                    if (hdr_flag_reg) begin
                        remaining_next = rd_word;
                        out_sop_next   = 1'b1;
                        out_eop_next   = (rd_word == '0);
                    end else begin
                        // eop fires as remaining reaches zero, so it never wraps
                        remaining_next = remaining_reg - 1'b1;
                        out_sop_next   = 1'b0;
                        out_eop_next   = (remaining_reg == W_WIDTH'(1));
                    end
                    state_next = OUT;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    hdr_flag_next = 1'b0;
                    if (out_eop_reg) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fifo_rd_en = (state_reg == READ) ? (grant_oh_reg & ~fifo_empty) : '0;
    assign out_valid  = (state_reg == OUT);
    assign out_data   = out_data_reg;
    assign out_sop    = out_sop_reg;
    assign out_eop    = out_eop_reg;
    assign out_port   = grant_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_switch_rd_sched.sv
// Directed bench for switch_rd_sched with a behavioural FIFO model per port.
module tb_switch_rd_sched;

    localparam int NP = 4;
    localparam int WW = 8;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     fifo_empty;
    logic [NP-1:0]     fifo_rd_en;
    logic [NP*WW-1:0]  fifo_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [WW-1:0]     out_data;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_port;
    logic              busy;

    always #5 clk = ~clk;

    switch_rd_sched #(
        .NUM_PORTS  (NP),
        .W_WIDTH    (WW),
        .RD_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_port     (out_port),
        .busy         (busy)
    );

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        int         cyc;
    } got_t;

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    logic [7:0] fq   [NP][$];
    logic [7:0] pipe [NP][RL];
    got_t       got  [$];
    exp_t       exp_tab [$];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int first_valid_cyc, first_rd_cyc, busy_cnt, proto_viol;

    logic [NP-1:0] s_rd_en;
    logic          s_valid, s_sop, s_eop, s_busy;
    logic [7:0]    s_data;
    logic [1:0]    s_port;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic add(input logic [1:0] p, input logic [7:0] d, input logic s, input logic e);
        exp_tab.push_back('{p, d, s, e});
    endtask

    task automatic push(input int p, input logic [7:0] d);
        fq[p].push_back(d);
    endtask

    task automatic update_model();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i]            = (fq[i].size() == 0);
            fifo_rd_data[i*WW +: WW] = pipe[i][RL-1];
        end
    endtask

    // One clock: sample on negedge, then advance the FIFO model after posedge
    task automatic cyc();
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_valid = out_valid;
        s_data  = out_data;
        s_sop   = out_sop;
        s_eop   = out_eop;
        s_port  = out_port;
        s_busy  = busy;
        if ($countones(s_rd_en) > 1) proto_viol++;
        if (s_rd_en != '0 && first_rd_cyc < 0) first_rd_cyc = cycle;
        if (s_valid && first_valid_cyc < 0) first_valid_cyc = cycle;
        if (s_busy) busy_cnt++;
        if (s_valid && out_ready) begin
            got.push_back('{s_port, s_data, s_sop, s_eop, cycle});
            $display("word port=%0d data=%02h sop=%0b eop=%0b cycle=%0d",
                     s_port, s_data, s_sop, s_eop, cycle);
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NP; i++) begin
            for (int k = RL - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
            if (s_rd_en[i]) begin
                if (fq[i].size() > 0) begin
                    pipe[i][0] = fq[i].pop_front();
                end else begin
                    pipe[i][0] = 8'hEE;
                    proto_viol++;
                end
            end else begin
                pipe[i][0] = 8'hEE;
            end
        end
        update_model();
    endtask

    task automatic wait_count(input int target, input string name);
        int budget;
        budget = 300;
        while (got.size() < target && budget > 0) begin
            cyc();
            budget--;
        end
        check({name, "_done"}, 64'(got.size() >= target), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        int budget;
        budget = 50;
        s_valid = 1'b0;
        while (!s_valid && budget > 0) begin
            cyc();
            budget--;
        end
        check({name, "_valid_seen"}, 64'(s_valid), 64'd1);
    endtask

    initial begin
        int base, c, viol;
        logic [7:0] ref_data;
        logic       ref_sop;
        logic [1:0] ref_port;

        // Expected words in the order the scenarios below produce them
        add(2, 8'h03, 1, 0); add(2, 8'hA1, 0, 0); add(2, 8'hA2, 0, 0); add(2, 8'hA3, 0, 1);
        add(0, 8'h00, 1, 1);
        add(3, 8'h01, 1, 0); add(3, 8'h33, 0, 1);
        add(1, 8'h02, 1, 0); add(1, 8'hB1, 0, 0); add(1, 8'hB2, 0, 1);
        add(2, 8'h05, 1, 0); add(2, 8'hC1, 0, 0);
        add(0, 8'h01, 1, 0); add(0, 8'h10, 0, 1);
        add(1, 8'h01, 1, 0); add(1, 8'h11, 0, 1);
        add(3, 8'h01, 1, 0); add(3, 8'h13, 0, 1);
        add(0, 8'h01, 1, 0); add(0, 8'h20, 0, 1);
        add(1, 8'h01, 1, 0); add(1, 8'h21, 0, 1);

        rst = 1'b1;
        out_ready = 1'b1;
        first_valid_cyc = -1;
        first_rd_cyc = -1;
        busy_cnt = 0;
        proto_viol = 0;
        for (int i = 0; i < NP; i++)
            for (int k = 0; k < RL; k++) pipe[i][k] = 8'hEE;
        update_model();
        repeat (3) cyc();
        check("reset_outputs", 64'({s_rd_en, s_valid, s_data, s_sop, s_eop, s_port, s_busy}), 64'd0);
        rst = 1'b0;
        cyc();

        // Single LEN=3 packet on port 2: latency and word spacing
        first_valid_cyc = -1;
        first_rd_cyc = -1;
        base = got.size();
        c = cycle;
        push(2, 8'h03); push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
        update_model();
        wait_count(base + 4, "single");
        check("first_rd_en_cycle", 64'(first_rd_cyc), 64'(c + 1));
        check("first_valid_cycle", 64'(first_valid_cyc), 64'(c + 2 + RL));
        for (int j = 1; j < 4; j++)
            if (got.size() > base + j)
                check("word_gap", 64'(got[base+j].cyc - got[base+j-1].cyc), 64'(RL + 2));
        repeat (2) cyc();

        // Zero-length packet on port 0: busy spans READ, WAIT and OUT only
        busy_cnt = 0;
        base = got.size();
        push(0, 8'h00);
        update_model();
        wait_count(base + 1, "zero_len");
        repeat (3) cyc();
        check("zero_len_busy_cycles", 64'(busy_cnt), 64'(RL + 2));

        // Backpressure on the header of a port 3 packet
        out_ready = 1'b0;
        base = got.size();
        push(3, 8'h01); push(3, 8'h33);
        update_model();
        wait_valid("bp");
        ref_data = s_data;
        ref_sop  = s_sop;
        ref_port = s_port;
        check("bp_header", 64'({s_port, s_data, s_sop, s_eop}), 64'({2'd3, 8'h01, 1'b1, 1'b0}));
        viol = 0;
        repeat (10) begin
            cyc();
            if (!s_valid || s_data !== ref_data || s_sop !== ref_sop ||
                s_port !== ref_port || s_rd_en !== '0) viol++;
        end
        check("bp_stable_no_read", 64'(viol), 64'd0);
        out_ready = 1'b1;
        wait_count(base + 2, "bp");
        repeat (2) cyc();

        // Underrun on port 1: last payload word arrives late
        base = got.size();
        push(1, 8'h02); push(1, 8'hB1);
        update_model();
        wait_count(base + 2, "underrun_head");
        viol = 0;
        repeat (6) begin
            cyc();
            if (s_rd_en !== '0 || s_valid || !s_busy) viol++;
        end
        check("underrun_hold", 64'(viol), 64'd0);
        push(1, 8'hB2);
        update_model();
        wait_count(base + 3, "underrun_tail");
        repeat (2) cyc();

        // Reset while the second payload word of a LEN=5 packet is presented
        base = got.size();
        push(2, 8'h05);
        push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3); push(2, 8'hC4); push(2, 8'hC5);
        update_model();
        wait_count(base + 2, "rst_mid_head");
        out_ready = 1'b0;
        wait_valid("rst_mid");
        check("rst_mid_word", 64'(s_data), 64'h00C2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("fifo_remainder", 64'(fq[2].size()), 64'd3);
        fq[2].delete();
        update_model();
        cyc();
        check("rst_mid_outputs", 64'({s_rd_en, s_valid, s_data, s_sop, s_eop, s_port, s_busy}), 64'd0);
        out_ready = 1'b1;

        // Round-robin: 0,1,3 together, then 0 and 1 refilled mid-round
        base = got.size();
        push(0, 8'h01); push(0, 8'h10);
        push(1, 8'h01); push(1, 8'h11);
        push(3, 8'h01); push(3, 8'h13);
        update_model();
        wait_count(base + 2, "rr_first");
        push(0, 8'h01); push(0, 8'h20);
        push(1, 8'h01); push(1, 8'h21);
        update_model();
        wait_count(base + 10, "rr_all");
        repeat (2) cyc();

        check("word_count", 64'(got.size()), 64'(exp_tab.size()));
        for (int i = 0; i < exp_tab.size(); i++) begin
            if (i < got.size())
                check($sformatf("word_%0d", i),
                      64'({got[i].port, got[i].data, got[i].sop, got[i].eop}),
                      64'({exp_tab[i].port, exp_tab[i].data, exp_tab[i].sop, exp_tab[i].eop}));
        end
        check("rd_en_protocol", 64'(proto_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
